// File: rtl/intpol2_d4_ctrl_if.sv
// Stream handshake bundle between the intpol2_d4 controller and its neighbours.
// The controller takes the slave side and the environment takes the master side.
interface intpol2_d4_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (output in_valid, output out_ready, input in_ready, input out_valid);
  modport slave  (input in_valid, input out_ready, output in_ready, output out_valid);
endinterface

// File: rtl/intpol2_d4_ctrl.sv
// Sequencing FSM for the intpol2_D4 quadratic-interpolation datapath.
// It loads a 3-sample window, emits interp_factor outputs, then slides the window.
module intpol2_d4_ctrl #(
  parameter int CNT_WIDTH = 8,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] interp_factor,
  input  logic [LEN_WIDTH-1:0] num_samples,
  intpol2_d4_ctrl_if.slave     stream,
  output logic                 busy,
  output logic                 done,
  output logic                 clear,
  output logic                 Ld_M0,
  output logic                 Ld_M1,
  output logic                 Ld_M2,
  output logic                 en_stream,
  output logic                 op_1,
  output logic                 en_sum,
  output logic [1:0]           sel_xi2,
  output logic                 sel_mult,
  output logic                 Ld_p1_xi,
  output logic                 Ld_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD0, S_LOAD1, S_LOAD2, S_COEF,
    S_MUL1, S_MUL2, S_OUT, S_SHIFT, S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_WIDTH-1:0] r_i;
  logic [CNT_WIDTH-1:0] r_factor;
  logic [LEN_WIDTH-1:0] r_consumed;
  logic [LEN_WIDTH-1:0] r_num;
  logic                 w_last;
  logic                 w_run_ok;
  logic                 w_take;

  assign w_last   = (r_i == r_factor - CNT_WIDTH'(1));
  assign w_run_ok = (num_samples >= LEN_WIDTH'(3));
  assign w_take   = Ld_M0 | Ld_M1 | Ld_M2 | en_stream;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // always_ff reads the pre-edge values of the others regardless of evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_i        <= '0;
      r_factor   <= '0;
      r_consumed <= '0;
      r_num      <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_num      <= num_samples;
        r_factor   <= (interp_factor == '0) ? CNT_WIDTH'(1) : interp_factor;
        r_consumed <= '0;
        r_i        <= '0;
      end
      if (w_take) r_consumed <= r_consumed + LEN_WIDTH'(1);
      // i restarts for every window and stops at factor-1.
      if (r_state == S_COEF)      r_i <= '0;
      else if (en_sum && !w_last) r_i <= r_i + CNT_WIDTH'(1);
    end
  end

  // NOTE: every output and the next state get a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next          = r_state;
    stream.in_ready = 1'b0;
    stream.out_valid = 1'b0;
    busy            = (r_state != S_IDLE);
    done            = 1'b0;
    clear           = 1'b0;
    Ld_M0           = 1'b0;
    Ld_M1           = 1'b0;
    Ld_M2           = 1'b0;
    en_stream       = 1'b0;
    op_1            = 1'b0;
    en_sum          = 1'b0;
    sel_xi2         = 2'b00;
    sel_mult        = 1'b0;
    Ld_p1_xi        = 1'b0;
    Ld_data         = 1'b0;

    if (r_state == S_MUL1 || r_state == S_MUL2 || r_state == S_OUT) begin
      if (r_i == '0)                 sel_xi2 = 2'b00;
      else if (r_i == CNT_WIDTH'(1)) sel_xi2 = 2'b01;
      else                           sel_xi2 = 2'b10;
    end

    case (r_state)
      S_IDLE: begin
        if (start) w_next = w_run_ok ? S_LOAD0 : S_DONE;
      end
      S_LOAD0: begin
        stream.in_ready = 1'b1;
        if (stream.in_valid) begin
          Ld_M0  = 1'b1;
          w_next = S_LOAD1;
        end
      end
      S_LOAD1: begin
        stream.in_ready = 1'b1;
        if (stream.in_valid) begin
          Ld_M1  = 1'b1;
          w_next = S_LOAD2;
        end
      end
      S_LOAD2: begin
        stream.in_ready = 1'b1;
        if (stream.in_valid) begin
          Ld_M2  = 1'b1;
          w_next = S_COEF;
        end
      end
      S_COEF: begin
        op_1   = 1'b1;
        clear  = 1'b1;
        w_next = S_MUL1;
      end
      S_MUL1: begin
        Ld_p1_xi = 1'b1;
        w_next   = S_MUL2;
      end
      S_MUL2: begin
        sel_mult = 1'b1;
        Ld_data  = 1'b1;
        w_next   = S_OUT;
      end
      S_OUT: begin
        stream.out_valid = 1'b1;
        sel_mult         = 1'b1;
        if (stream.out_ready) begin
          en_sum = 1'b1;
          if (w_last) w_next = (r_consumed == r_num) ? S_DONE : S_SHIFT;
          else        w_next = S_MUL1;
        end
      end
      S_SHIFT: begin
        stream.in_ready = 1'b1;
        if (stream.in_valid) begin
          en_stream = 1'b1;
          w_next    = S_COEF;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_intpol2_d4_ctrl.sv
// Randomized scoreboard bench for intpol2_d4_ctrl: the driver pushes the expected
// output sequence of each run, and a negedge monitor pops and checks it on every handshake.
module tb_intpol2_d4_ctrl;
  localparam int CW = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] interp_factor = '0;
  logic [LW-1:0] num_samples = '0;
  logic busy, done, clear, Ld_M0, Ld_M1, Ld_M2, en_stream, op_1, en_sum;
  logic sel_mult, Ld_p1_xi, Ld_data;
  logic [1:0] sel_xi2;
  logic [15:0] all_outs;

  intpol2_d4_ctrl_if sif ();

  intpol2_d4_ctrl #(.CNT_WIDTH(CW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .interp_factor(interp_factor),
    .num_samples(num_samples), .stream(sif), .busy(busy), .done(done), .clear(clear),
    .Ld_M0(Ld_M0), .Ld_M1(Ld_M1), .Ld_M2(Ld_M2), .en_stream(en_stream), .op_1(op_1),
    .en_sum(en_sum), .sel_xi2(sel_xi2), .sel_mult(sel_mult), .Ld_p1_xi(Ld_p1_xi),
    .Ld_data(Ld_data)
  );

  always #5 clk = ~clk;

  assign all_outs = {busy, done, clear, Ld_M0, Ld_M1, Ld_M2, en_stream, op_1, en_sum,
                     sel_xi2, sel_mult, Ld_p1_xi, Ld_data, sif.in_ready, sif.out_valid};

  typedef struct {
    int         win;
    int         idx;
    logic [1:0] sel;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;

  // Run context shared between driver and monitor.
  int exp_w = 0, exp_f = 1;
  bit tied = 0, run_done = 0;
  int cyc = 0, k0 = 0, first_ov = -1, last_hs = -1;
  int ld_cnt = 0, st_cnt = 0, op_cnt = 0;
  bit prev_fill = 0, prev_p1 = 0, prev_ldd = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: protocol invariants every cycle, scoreboard pop on each output handshake.
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      check("outs_in_reset", 32'(all_outs), 0);
      prev_fill = 0;
      prev_p1   = 0;
      prev_ldd  = 0;
    end else begin
      if (start && !busy) begin
        ld_cnt = 0; st_cnt = 0; op_cnt = 0;
        first_ov = -1; last_hs = -1;
        k0 = cyc + 1;
      end
      if (!busy) check("idle_quiet", 32'(all_outs), 0);
      if (Ld_M0) check("ld_m0_order", ld_cnt, 0);
      if (Ld_M1) check("ld_m1_order", ld_cnt, 1);
      if (Ld_M2) check("ld_m2_order", ld_cnt, 2);
      if (Ld_M0 | Ld_M1 | Ld_M2 | en_stream) begin
        check("ld_vs_stream", 32'((Ld_M0 | Ld_M1 | Ld_M2) & en_stream), 0);
        check("load_handshake", 32'(sif.in_valid & sif.in_ready), 1);
      end
      check("en_sum", 32'(en_sum), 32'(sif.out_valid & sif.out_ready));
      check("op1_after_fill", 32'(op_1), 32'(prev_fill));
      check("clear_with_op1", 32'(clear), 32'(op_1));
      check("ld_data_after_p1", 32'(Ld_data), 32'(prev_p1));
      if (prev_ldd) check("valid_after_ld_data", 32'(sif.out_valid), 1);
      if (Ld_p1_xi) check("sel_mult_p1", 32'(sel_mult), 0);
      if (sif.out_valid) begin
        check("out_strobes", 32'({sel_mult, Ld_data, Ld_p1_xi, sif.in_ready}), 32'(4'b1000));
        if (first_ov < 0) first_ov = cyc;
        if (sif.out_ready) begin
          if (sb.size() == 0) begin
            check("extra_output", 1, 0);
          end else begin
            e = sb.pop_front();
            check("sel_xi2", 32'(sel_xi2), 32'(e.sel));
            check("window", ld_cnt + st_cnt - 3, e.win);
          end
          last_hs = cyc;
        end
      end
      if (done) begin
        check("outputs_left", sb.size(), 0);
        check("op1_count", op_cnt, exp_w);
        check("stream_count", st_cnt, (exp_w > 0) ? exp_w - 1 : 0);
        check("load_count", ld_cnt, (exp_w > 0) ? 3 : 0);
        if (exp_w == 0) check("done_latency", cyc, k0);
        else            check("done_after_last", cyc, last_hs + 1);
        if (tied && exp_w > 0) begin
          check("first_out_latency", first_ov, k0 + 6);
          check("run_length", cyc, k0 + 2 + exp_w * (2 + 3 * exp_f));
        end
        run_done = 1;
      end
      ld_cnt   += int'(Ld_M0) + int'(Ld_M1) + int'(Ld_M2);
      st_cnt   += int'(en_stream);
      op_cnt   += int'(op_1);
      prev_fill = Ld_M2 | en_stream;
      prev_p1   = Ld_p1_xi;
      prev_ldd  = Ld_data;
    end
  end

  // One run: reference outputs come straight from window/index arithmetic.
  task automatic run(input int n, input int f, input int piv, input int por, input bit hold);
    int  f_eff;
    int  held;
    bit  finished;
    exp_t x;
    f_eff = (f == 0) ? 1 : f;
    exp_f = f_eff;
    exp_w = (n >= 3) ? n - 2 : 0;
    tied  = (piv >= 100) && (por >= 100) && !hold;
    for (int w = 0; w < exp_w; w++) begin
      for (int i = 0; i < f_eff; i++) begin
        x.win = w;
        x.idx = i;
        x.sel = (i == 0) ? 2'b00 : (i == 1) ? 2'b01 : 2'b10;
        sb.push_back(x);
      end
    end
    run_done = 0;
    held     = 0;
    finished = 0;
    @(posedge clk); #1;
    start         = 1'b1;
    interp_factor = CW'(f);
    num_samples   = LW'(n);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (run_done) begin
        finished = 1;
        break;
      end
      // Scrambled parameters and start pulses while busy must not disturb the run.
      start         = sif.out_valid && ($urandom_range(0, 3) == 0);
      interp_factor = CW'($urandom);
      num_samples   = LW'($urandom);
      sif.in_valid  = ($urandom_range(0, 99) < piv);
      if (hold && sif.out_valid && held < 5) begin
        check("hold_out_valid", 32'(sif.out_valid), 1);
        sif.out_ready = 1'b0;
        held++;
      end else begin
        sif.out_ready = ($urandom_range(0, 99) < por);
      end
    end
    start = 1'b0;
    if (!finished) begin
      check("run_timeout", 0, 1);
      rstn = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      rstn = 1'b1;
    end else begin
      check("idle_after_done", 32'(busy), 0);
    end
    sif.in_valid  = 1'b0;
    sif.out_ready = 1'b0;
  endtask

  initial begin
    bit seen;
    sif.in_valid  = 1'b0;
    sif.out_ready = 1'b0;
    #2;
    check("reset_outs", 32'(all_outs), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    run(3, 4, 100, 100, 0);
    run(5, 2, 100, 100, 0);
    run(4, 0, 100, 100, 0);
    run(2, 5, 100, 100, 0);
    run(6, 3, 60, 70, 1);
    run(5, 3, 30, 100, 0);
    for (int r = 0; r < 8; r++)
      run($urandom_range(0, 7), $urandom_range(0, 4), $urandom_range(40, 100),
          $urandom_range(40, 100), 0);

    // Abandon a run while it sits in OUT; no done may follow.
    exp_w = 0;
    tied  = 0;
    seen  = 0;
    @(posedge clk); #1;
    start         = 1'b1;
    interp_factor = CW'(3);
    num_samples   = LW'(5);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      start         = 1'b0;
      sif.in_valid  = 1'b1;
      sif.out_ready = 1'b0;
      if (sif.out_valid) begin
        seen = 1;
        break;
      end
    end
    check("reached_out", 32'(seen), 1);
    rstn = 1'b0;
    #1;
    check("async_reset_outs", 32'(all_outs), 0);
    sb.delete();
    sif.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    run(3, 1, 100, 100, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/intpol2_d4_ctrl.md
Name: intpol2_D4_ctrl

Overview:
Sequencing FSM for the intpol2_D4 quadratic-interpolation datapath. It takes an input stream of samples and produces interp_factor output samples per 3-sample window. It generates every datapath strobe: M-register loads, coefficient latch, xi/xi² stepping, multiplier mux select, p1·xi latch, output latch and window streaming. It sits between the stream interfaces and the datapath, and it owns both the input and output valid/ready handshakes.

Parameters:
CNT_WIDTH, 8, width of interp_factor and of the internal output-index counter i.
LEN_WIDTH, 16, width of num_samples and of the consumed-sample counter.

Ports:
clk  in  1  clock.
rstn  in  1  reset; asynchronous, active-low.
start  in  1  begin a run; sampled only in IDLE.
interp_factor  in  CNT_WIDTH  outputs per window; latched on start; 0 is treated as 1.
num_samples  in  LEN_WIDTH  total input samples in the run; latched on start.
in_valid  in  1  input sample present on the datapath data_to_process bus.
in_ready  out  1  controller accepts a sample this cycle.
out_valid  out  1  datapath data_out holds a valid interpolated sample.
out_ready  in  1  downstream accepts the output.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at end of run.
clear  out  1  clears the xi and xi² accumulators.
Ld_M0, Ld_M1, Ld_M2  out  1 each  load the window registers.
en_stream  out  1  shift the window (m0<=m1, m1<=m2, m2<=new).
op_1  out  1  latch p1/p2.
en_sum  out  1  advance xi and xi².
sel_xi2  out  2  squared-unit step select.
sel_mult  out  1  multiplier mux: 0 selects p1·xi, 1 selects p2·xi².
Ld_p1_xi  out  1  latch p1·xi.
Ld_data  out  1  latch the adder3 result into the output register.

Behaviour:
- Reset state: IDLE. All outputs are 0 at reset, and i and the consumed counter are cleared.
- Control strobes are combinational decodes of state plus handshake inputs. Each strobe lasts exactly one cycle unless stated otherwise.
- IDLE: in_ready=0, busy=0.
  - start with num_samples<3 → DONE, with no loads and no outputs.
  - Otherwise: latch parameters, consumed=0 → LOAD0.
- LOAD0, LOAD1, LOAD2: in_ready=1.
  - On in_valid, assert Ld_Mk in the same cycle, consumed++, and go to the next state. LOAD2 proceeds to COEF.
  - Without in_valid, wait; no strobes.
- COEF: op_1=1, clear=1, i<=0 → MUL1.
- MUL1: sel_mult=0, Ld_p1_xi=1 → MUL2.
- MUL2: sel_mult=1, Ld_data=1 → OUT.
- OUT: out_valid=1 and sel_mult=1. Output data and all strobes stay stable until out_ready.
  - On out_ready: en_sum=1.
  - If i==factor-1: go to DONE when consumed==num_samples, else to SHIFT.
  - Otherwise: i++ → MUL1.
- SHIFT: in_ready=1. On in_valid: en_stream=1, consumed++ → COEF.
- DONE: done=1, busy=1 → IDLE.
- sel_xi2 decoding: 2'b00 while i==0, 2'b01 while i==1, 2'b10 while i>=2. It is driven in all states; it reads 00 outside MUL1/MUL2/OUT.
- Latency:
  - First out_valid appears 3 cycles after entering COEF.
  - With out_ready held high, the output rate is one sample per 3 cycles.
  - The window switch costs SHIFT+COEF, i.e. 2 cycles when in_valid is high.
- Total outputs per run = (num_samples−2)·max(interp_factor,1).
- Boundaries:
  - start while busy is ignored; latched parameters do not change mid-run.
  - in_ready is never asserted outside the LOADk and SHIFT states, so surplus input is back-pressured.
  - out_ready while out_valid=0 is ignored.
  - Ld_Mk and en_stream are never asserted in the same cycle.
  - rstn low at any time returns asynchronously to IDLE with all outputs 0. A run in progress is abandoned, and no done pulse is produced.
  - i never exceeds factor−1. The counters do not wrap within a legal run.

Test Plan:
- num_samples=3, factor=4, in_valid and out_ready tied high → Ld_M0/1/2 on three consecutive cycles; op_1 once; 4 out_valid pulses 3 cycles apart; sel_xi2 sequence 00,01,10,10; en_sum×4; done 1 cycle after the last handshake; no en_stream.
- num_samples=5, factor=2 → 6 outputs; en_stream pulses exactly twice, each followed next cycle by op_1+clear; done once.
- Hold out_ready=0 for 5 cycles in OUT → out_valid held; en_sum, Ld_data and Ld_p1_xi stay 0; the state does not advance; exactly one en_sum on release.
- Random in_valid gaps during LOAD1 and SHIFT → in_ready stays high while waiting; loads occur only on in_valid cycles; output count unchanged.
- factor=0, num_samples=4 → behaves as factor=1: 2 outputs, 1 en_stream. num_samples=2 → done one cycle after start, no other strobes.
- Assert rstn=0 mid-OUT, then release and start a new run (num_samples=3, factor=1) → all outputs 0 immediately at reset; the new run yields exactly 1 output and a correct done pulse.
